// File: rtl/taiga_trace_counter_bank.sv
// Bank of runtime-selectable trace event counters with wrap/saturate modes,
// overflow flags/interrupt and a 1-cycle register read port with hi-half shadow.
module taiga_trace_counter_bank #(
  parameter int NUM_EVENTS   = 19,
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 48,
  parameter int ADDR_W       = $clog2(NUM_COUNTERS) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  global_freeze,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr,
  input  logic [31:0]           wdata,
  input  logic                  rd,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  overflow_irq
);

  localparam int HI_W = COUNTER_W - 32;

  if (COUNTER_W < 33 || COUNTER_W > 64) begin : g_bad_counter_w
    $error("taiga_trace_counter_bank: COUNTER_W must be within 33..64");
  end
  if (NUM_COUNTERS < 1 || NUM_COUNTERS > 16) begin : g_bad_num_counters
    $error("taiga_trace_counter_bank: NUM_COUNTERS must be within 1..16");
  end

  logic [COUNTER_W-1:0]    cnt     [NUM_COUNTERS];
  logic [COUNTER_W-1:0]    cnt_nxt [NUM_COUNTERS];
  logic [HI_W-1:0]         shadow  [NUM_COUNTERS];
  logic [7:0]              evt_sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] enable, saturate, irq_en, ovf_flag;
  logic [NUM_COUNTERS-1:0] inc, wr_hit, ovf_set;
  logic [COUNTER_W:0]      bumped;
  logic [ADDR_W-1:0]       sel_idx;
  logic [1:0]              reg_sel;
  logic                    in_range;
  logic [31:0]             rd_word;

  assign sel_idx  = addr >> 2;
  assign reg_sel  = addr[1:0];
  assign in_range = sel_idx < ADDR_W'(NUM_COUNTERS);

  function automatic logic ev_hit(input logic [NUM_EVENTS-1:0] ev, input logic [7:0] sel);
    logic [NUM_EVENTS-1:0] sh;
    sh = ev >> sel;
    return sh[0];
  endfunction

  // Returns {overflow, next_count}; all-ones either wraps to zero or holds.
  function automatic logic [COUNTER_W:0] bump(input logic [COUNTER_W-1:0] c, input logic sat);
    if (&c) return {1'b1, (sat ? c : {COUNTER_W{1'b0}})};
    return {1'b0, c + COUNTER_W'(1)};
  endfunction

  always_comb begin
    inc    = '0;
    wr_hit = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc[i]    = enable[i] & ~global_freeze & (32'(evt_sel[i]) < NUM_EVENTS) &
                  ev_hit(events, evt_sel[i]);
      wr_hit[i] = wr & in_range & (sel_idx == ADDR_W'(i));
    end
  end

  // A register write to either count half takes priority over the increment.
  always_comb begin
    bumped  = '0;
    ovf_set = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (wr_hit[i] && reg_sel == 2'd1) begin
        cnt_nxt[i][31:0] = wdata;
      end else if (wr_hit[i] && reg_sel == 2'd2) begin
        cnt_nxt[i][COUNTER_W-1:32] = wdata[HI_W-1:0];
      end else if (inc[i]) begin
        bumped     = bump(cnt[i], saturate[i]);
        cnt_nxt[i] = bumped[COUNTER_W-1:0];
        ovf_set[i] = bumped[COUNTER_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (in_range && sel_idx == ADDR_W'(i)) begin
        case (reg_sel)
          2'd0:    rd_word = {20'd0, ovf_flag[i], irq_en[i], saturate[i], enable[i], evt_sel[i]};
          2'd1:    rd_word = cnt[i][31:0];
          2'd2:    rd_word = 32'(shadow[i]);
          default: rd_word = '0;
        endcase
      end
    end
  end

  // Register stage: counts, config, shadow, read data and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i]     <= '0;
        shadow[i]  <= '0;
        evt_sel[i] <= '0;
      end
      enable       <= '0;
      saturate     <= '0;
      irq_en       <= '0;
      ovf_flag     <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      overflow_irq <= 1'b0;
    end else begin
      rdata_valid  <= rd;
      if (rd) rdata <= rd_word;
      overflow_irq <= |(ovf_flag & irq_en);
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (rd && in_range && sel_idx == ADDR_W'(i) && reg_sel == 2'd1)
          shadow[i] <= cnt[i][COUNTER_W-1:32];
        if (wr_hit[i] && reg_sel == 2'd0) begin
          evt_sel[i]  <= wdata[7:0];
          enable[i]   <= wdata[8];
          saturate[i] <= wdata[9];
          irq_en[i]   <= wdata[10];
        end
        if (ovf_set[i])
          ovf_flag[i] <= 1'b1;
        else if (wr_hit[i] && reg_sel == 2'd0 && wdata[11])
          ovf_flag[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_taiga_trace_counter_bank.sv
// Directed bench for taiga_trace_counter_bank with the default parameters
// (19 events, 4 counters, 48-bit counts, 4-bit address).
module tb_taiga_trace_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] events = '0;
  logic        global_freeze = 1'b0;
  logic [3:0]  addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        overflow_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] val;

  localparam logic [18:0] EV5 = 19'h20;

  taiga_trace_counter_bank dut (
    .clk          (clk),
    .rst          (rst),
    .events       (events),
    .global_freeze(global_freeze),
    .addr         (addr),
    .wr           (wr),
    .wdata        (wdata),
    .rd           (rd),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .overflow_irq (overflow_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic read_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    chk({tag, "_valid"}, 32'(rdata_valid), 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic pulse(input logic [18:0] ev, input int n);
    @(negedge clk);
    events = ev;
    repeat (n) @(negedge clk);
    events = '0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_irq", 32'(overflow_irq), 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    read_reg("rst_cfg0", 4'd0, 32'd0);
    read_reg("rst_lo0", 4'd1, 32'd0);
    read_reg("rst_cfg3", 4'd12, 32'd0);

    // Basic count on counter 0
    write_reg(4'd0, 32'h105);
    pulse(EV5, 10);
    read_reg("cnt0_lo", 4'd1, 32'd10);
    read_reg("cnt0_hi", 4'd2, 32'd0);
    @(negedge clk);
    chk("idle_valid", 32'(rdata_valid), 32'd0);
    chk("idle_hold", rdata, 32'd0);
    read_reg("cnt0_cfg", 4'd0, 32'h105);
    read_reg("reserved", 4'd3, 32'd0);

    // Wrap mode with interrupt on counter 1
    write_reg(4'd5, 32'hFFFF_FFFE);
    write_reg(4'd6, 32'h0000_FFFF);
    write_reg(4'd4, 32'h505);
    @(negedge clk);
    events = EV5;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_irq_early", 32'(overflow_irq), 32'd0);
    @(negedge clk);
    events = '0;
    chk("wrap_irq", 32'(overflow_irq), 32'd1);
    read_reg("wrap_lo", 4'd5, 32'd1);
    read_reg("wrap_hi", 4'd6, 32'd0);
    read_reg("wrap_cfg", 4'd4, 32'hD05);
    write_reg(4'd4, 32'hD05);
    chk("irq_clear_lag", 32'(overflow_irq), 32'd1);
    @(negedge clk);
    chk("irq_cleared", 32'(overflow_irq), 32'd0);
    read_reg("wrap_cfg_clr", 4'd4, 32'h505);

    // Saturate mode on counter 2, no interrupt enable
    write_reg(4'd9, 32'hFFFF_FFFE);
    write_reg(4'd10, 32'h0000_FFFF);
    write_reg(4'd8, 32'h305);
    pulse(EV5, 5);
    read_reg("sat_lo", 4'd9, 32'hFFFF_FFFF);
    read_reg("sat_hi", 4'd10, 32'h0000_FFFF);
    read_reg("sat_cfg", 4'd8, 32'hB05);
    chk("sat_no_irq", 32'(overflow_irq), 32'd0);

    // Shadow atomicity on counter 3
    write_reg(4'd13, 32'hFFFF_FFFF);
    write_reg(4'd14, 32'h1);
    write_reg(4'd12, 32'h105);
    read_reg("shd_lo", 4'd13, 32'hFFFF_FFFF);
    pulse(EV5, 1);
    read_reg("shd_hi", 4'd14, 32'h1);
    read_reg("shd_lo2", 4'd13, 32'h0);
    read_reg("shd_hi2", 4'd14, 32'h2);

    // Write beats increment in the same cycle
    @(negedge clk);
    events = EV5; addr = 4'd1; wdata = 32'h100; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; events = '0;
    read_reg("wr_wins", 4'd1, 32'h100);

    // Freeze and out-of-range event select
    global_freeze = 1'b1;
    pulse(EV5, 4);
    global_freeze = 1'b0;
    read_reg("freeze", 4'd1, 32'h100);
    write_reg(4'd0, 32'h1C8);
    pulse('1, 4);
    read_reg("sel200", 4'd1, 32'h100);
    write_reg(4'd3, 32'hFFFF_FFFF);
    read_reg("rsvd_wr", 4'd0, 32'h1C8);

    // Same-cycle read and write of CNT_LO
    write_reg(4'd1, 32'd7);
    @(negedge clk);
    addr = 4'd1; wdata = 32'd9; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    chk("rdwr_valid", 32'(rdata_valid), 32'd1);
    chk("rdwr_old", rdata, 32'd7);
    read_reg("rdwr_new", 4'd1, 32'd9);

    // Asynchronous reset in the middle of counting
    write_reg(4'd0, 32'h105);
    @(negedge clk);
    events = EV5;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rdata_valid), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    events = '0;
    @(negedge clk);
    rst = 1'b0;
    read_reg("arst_lo0", 4'd1, 32'd0);
    read_reg("arst_cfg0", 4'd0, 32'd0);
    read_reg("arst_cfg2", 4'd8, 32'd0);
    read_reg("arst_lo3", 4'd13, 32'd0);
    read_reg("arst_hi3", 4'd14, 32'd0);
    chk("arst_irq", 32'(overflow_irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
